// File: rtl/imm_encoder.sv
// Immediate-field encoder: merges a signed immediate into an instruction template.
// An out-of-range I-format immediate can instead be expanded into a LUI + ADDI pair.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_sel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  input  logic        expand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_J = 3'b011;
  localparam logic [2:0] SEL_U = 3'b100;

  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addi_q, addi_d;
  logic        err_q, err_d;
  logic        last_q, last_d;

  logic [31:0] dec_instr;
  logic [31:0] dec_addi;
  logic        dec_err;
  logic        dec_last;
  logic        dec_two;
  logic [31:0] enc;
  logic        ok;
  logic [31:0] lui_sum;
  logic [4:0]  rd;
  logic        accept;
  logic        load;

  function automatic logic fits(input logic signed [31:0] v,
                                input logic signed [31:0] lo,
                                input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Decode: place the immediate for the selected format and judge legality.
  always_comb begin
    enc     = base;
    ok      = 1'b0;
    rd      = base[11:7];
    lui_sum = imm + 32'h0000_0800;
    case (imm_sel)
      SEL_I: begin
        enc = {imm[11:0], base[19:0]};
        ok  = fits(imm, -32'sd2048, 32'sd2047);
      end
      SEL_S: begin
        enc = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        ok  = fits(imm, -32'sd2048, 32'sd2047);
      end
      SEL_B: begin
        enc = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        ok  = fits(imm, -32'sd4096, 32'sd4094) && !imm[0];
      end
      SEL_J: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        ok  = fits(imm, -32'sd1048576, 32'sd1048574) && !imm[0];
      end
      SEL_U: begin
        enc = {imm[31:12], base[11:0]};
        ok  = (imm[11:0] == 12'h000);
      end
      default: begin
        enc = base;
        ok  = 1'b0;
      end
    endcase
    if (expand && (imm_sel != SEL_I)) ok = 1'b0;

    dec_instr = base;
    dec_addi  = '0;
    dec_err   = 1'b1;
    dec_last  = 1'b1;
    dec_two   = 1'b0;
    if (ok) begin
      dec_instr = enc;
      dec_err   = 1'b0;
    end else if ((imm_sel == SEL_I) && expand) begin
      // The +0x800 bias compensates for ADDI sign-extending its 12-bit operand.
      dec_instr = {lui_sum[31:12], rd, OPC_LUI};
      dec_addi  = {imm[11:0], rd, 3'b000, rd, OPC_ADDI};
      dec_err   = 1'b0;
      dec_two   = (imm[11:0] != 12'h000);
      dec_last  = !dec_two;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_last  = last_q;
  assign in_ready  = !rst && (!out_valid || (out_ready && out_last));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addi_d  = addi_q;
    err_d   = err_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = accept;
      HI: begin
        if (out_ready) begin
          state_d = ONE;
          instr_d = addi_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
        end
      end
      ONE: begin
        if (out_ready) begin
          if (accept) load = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = dec_two ? HI : ONE;
      instr_d = dec_instr;
      addi_d  = dec_addi;
      err_d   = dec_err;
      last_d  = dec_last;
    end
  end

  // State and output beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  // Pending ADDI word is only meaningful in HI, so it carries no reset.
  always_ff @(posedge clk) begin
    addi_q <= addi_d;
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against a queue-based beat model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [31:0] base;
  logic        expand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  bit check_rst = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } beat_t;

  beat_t q[$];

  imm_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .base(base), .expand(expand),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic [31:0] ins, input logic e, input logic l);
    beat_t b;
    b.instr = ins;
    b.err   = e;
    b.last  = l;
    q.push_back(b);
  endfunction

  // Reference: immediate fields placed by mask/shift arithmetic from the format tables.
  function automatic void model(input logic [2:0] sel, input logic [31:0] im,
                                input logic [31:0] bs, input logic ex);
    int          si;
    bit          ok;
    logic [31:0] m, f, rdv, hi;
    si = int'(im);
    ok = 1'b0;
    m  = 32'h0;
    f  = 32'h0;
    case (sel)
      3'd0: begin
        ok = (si >= -2048) && (si <= 2047);
        m  = 32'hFFF0_0000;
        f  = (im & 32'hFFF) << 20;
      end
      3'd1: begin
        ok = (si >= -2048) && (si <= 2047);
        m  = 32'hFE00_0F80;
        f  = (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
      end
      3'd2: begin
        ok = (si >= -4096) && (si <= 4094) && ((im & 32'h1) == 0);
        m  = 32'hFE00_0F80;
        f  = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) |
             (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        ok = (si >= -1048576) && (si <= 1048574) && ((im & 32'h1) == 0);
        m  = 32'hFFFF_F000;
        f  = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
             (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12);
      end
      3'd4: begin
        ok = ((im & 32'hFFF) == 0);
        m  = 32'hFFFF_F000;
        f  = im & 32'hFFFF_F000;
      end
      default: ok = 1'b0;
    endcase
    if (ex && (sel != 3'd0)) ok = 1'b0;
    if (ok) begin
      push((bs & ~m) | f, 1'b0, 1'b1);
    end else if ((sel == 3'd0) && ex) begin
      rdv = (bs >> 7) & 32'h1F;
      hi  = ((im + 32'h800) & 32'hFFFF_F000) | (rdv << 7) | 32'h37;
      if ((im & 32'hFFF) == 0) begin
        push(hi, 1'b0, 1'b1);
      end else begin
        push(hi, 1'b0, 1'b0);
        push(((im & 32'hFFF) << 20) | (rdv << 15) | (rdv << 7) | 32'h13, 1'b0, 1'b1);
      end
    end else begin
      push(bs, 1'b1, 1'b1);
    end
  endfunction

  task automatic step(input logic v, input logic [2:0] sel, input logic [31:0] im,
                      input logic [31:0] bs, input logic ex, input logic rdy, input logic r);
    bit exp_ready;
    @(posedge clk);
    #1;
    in_valid  = v;
    imm_sel   = sel;
    imm       = im;
    base      = bs;
    expand    = ex;
    out_ready = rdy;
    rst       = r;
    @(negedge clk);
    if (check_rst) begin
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_err", {31'h0, out_err}, 32'h0);
      chk("rst_last", {31'h0, out_last}, 32'h0);
      check_rst = 1'b0;
    end
    exp_ready = !rst && ((q.size() == 0) || ((q.size() == 1) && out_ready));
    chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
    if (q.size() > 0) begin
      chk("beat_instr", out_instr, q[0].instr);
      chk("beat_err", {31'h0, out_err}, {31'h0, q[0].err});
      chk("beat_last", {31'h0, out_last}, {31'h0, q[0].last});
    end
    if (rst) begin
      q.delete();
      check_rst = 1'b1;
    end else begin
      if ((q.size() > 0) && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) model(imm_sel, imm, base, expand);
    end
  endtask

  task automatic idle(input logic rdy, input logic r);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, rdy, r);
  endtask

  task automatic single(input string tag, input logic [2:0] sel, input logic [31:0] im,
                        input logic [31:0] bs, input logic ex,
                        input logic [31:0] exp_instr, input logic exp_err);
    step(1'b1, sel, im, bs, ex, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"}, {31'h0, out_err}, {31'h0, exp_err});
    chk({tag, "_last"}, {31'h0, out_last}, 32'h1);
    idle(1'b1, 1'b0);
  endtask

  logic [31:0] corners [0:15];

  initial begin
    logic [31:0] rimm;
    corners = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF,
                32'hFFFF_F000, 32'h0000_0FFE, 32'h0000_1000, 32'h000F_FFFE,
                32'hFFF0_0000, 32'h0010_0000, 32'h0000_0000, 32'h7FFF_F800,
                32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5000};
    rst = 1'b1; in_valid = 1'b0; imm_sel = 3'd0; imm = 32'h0; base = 32'h0;
    expand = 1'b0; out_ready = 1'b0;

    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("ready_after_rst", {31'h0, in_ready}, 32'h1);

    single("i_neg1", 3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 1'b0, 32'hFFF0_0093, 1'b0);
    single("b_8", 3'd2, 32'h0000_0008, 32'h0000_0063, 1'b0, 32'h0000_0463, 1'b0);
    single("j_2048", 3'd3, 32'h0000_0800, 32'h0000_006F, 1'b0, 32'h0010_006F, 1'b0);
    single("u_1000", 3'd4, 32'h0000_1000, 32'h0000_0037, 1'b0, 32'h0000_1037, 1'b0);
    single("b_mis", 3'd2, 32'h0000_0003, 32'h0000_0063, 1'b0, 32'h0000_0063, 1'b1);
    single("sel7", 3'd7, 32'h0000_0008, 32'h0000_0063, 1'b0, 32'h0000_0063, 1'b1);
    single("s_exp", 3'd1, 32'h0000_0004, 32'h0000_0023, 1'b1, 32'h0000_0023, 1'b1);
    single("i_big", 3'd0, 32'h0000_0800, 32'h0000_0093, 1'b0, 32'h0000_0093, 1'b1);
    single("lui_only", 3'd0, 32'h0001_0000, 32'h0000_0093, 1'b1, 32'h0001_00B7, 1'b0);

    // Expansion with a three-cycle stall, then a back-to-back request on drain.
    step(1'b1, 3'd0, 32'h1234_5FFF, 32'h0000_0093, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b0);
      chk("stall_lui", out_instr, 32'h1234_60B7);
      chk("stall_last", {31'h0, out_last}, 32'h0);
      chk("stall_ready", {31'h0, in_ready}, 32'h0);
    end
    idle(1'b1, 1'b0);
    chk("hi_ready", {31'h0, in_ready}, 32'h0);
    step(1'b1, 3'd0, 32'h0000_0005, 32'h0000_0093, 1'b0, 1'b1, 1'b0);
    chk("addi_instr", out_instr, 32'hFFF0_8093);
    chk("addi_last", {31'h0, out_last}, 32'h1);
    chk("addi_err", {31'h0, out_err}, 32'h0);
    chk("b2b_ready", {31'h0, in_ready}, 32'h1);
    idle(1'b1, 1'b0);
    chk("b2b_instr", out_instr, 32'h0050_0093);
    idle(1'b1, 1'b0);

    // Reset while the ADDI beat is pending.
    step(1'b1, 3'd0, 32'h1234_5FFF, 32'h0000_0093, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("pre_rst_lui", out_instr, 32'h1234_60B7);
    idle(1'b1, 1'b1);
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    idle(1'b1, 1'b0);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h0);
    idle(1'b1, 1'b0);
    chk("no_addi", {31'h0, out_valid}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: rimm = $urandom_range(0, 4095) - 32'd2048;
        1: rimm = $urandom;
        2: rimm = $urandom_range(0, 8191) - 32'd4096;
        3: rimm = $urandom & 32'hFFFF_F000;
        4: rimm = $urandom_range(0, 2097151) - 32'd1048576;
        default: rimm = corners[$urandom_range(0, 15)];
      endcase
      step($urandom_range(0, 9) < 6,
           ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
           rimm, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
    end
    for (int n = 0; n < 4; n++) idle(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (in, 1) is the clock, and rst (in, 1) is the reset.
REQ-002 SHALL have the following input-side ports:
- in_valid (in, 1): request valid.
- in_ready (out, 1): encoder can accept a request.
- imm_sel (in, 3): immediate format. 000=I, 001=S, 010=B, 011=J, 100=U.
- imm (in, 32): signed byte-offset or constant to encode.
- base (in, 32): instruction template; every immediate bit position in it is overwritten.
- expand (in, 1): allow two-beat LUI+ADDI expansion, valid only for I format.
REQ-003 SHALL have the following output-side ports:
- out_valid (out, 1): beat valid.
- out_ready (in, 1): downstream accepts the beat.
- out_instr (out, 32): encoded instruction.
- out_err (out, 1): request could not be encoded.
- out_last (out, 1): final beat of the request.

Function
REQ-004 SHALL accept a request when in_valid and in_ready are both 1 at a rising clk edge.
REQ-005 SHALL drive in_ready = !out_valid || (out_ready && out_last), so a new request is accepted in the same cycle the final beat drains.
REQ-006 SHALL present the first beat in the cycle after acceptance (latency 1).
REQ-007 SHALL hold out_instr, out_err and out_last stable while out_valid=1 and out_ready=0.
REQ-008 I format: imm SHALL lie in [-2048, 2047]. Encoding: instr[31:20] = imm[11:0].
REQ-009 S format: imm SHALL lie in [-2048, 2047]. Encoding: instr[31:25] = imm[11:5], instr[11:7] = imm[4:0].
REQ-010 B format: imm SHALL lie in [-4096, 4094] and imm[0] SHALL be 0. Encoding: instr[31] = imm[12], instr[7] = imm[11], instr[30:25] = imm[10:5], instr[11:8] = imm[4:1].
REQ-011 J format: imm SHALL lie in [-2^20, 2^20-2] and imm[0] SHALL be 0. Encoding: instr[31] = imm[20], instr[30:21] = imm[10:1], instr[20] = imm[11], instr[19:12] = imm[19:12].
REQ-012 U format: imm[11:0] SHALL be 0. Encoding: instr[31:12] = imm[31:12].
REQ-013 All non-immediate bits of out_instr SHALL equal base.
REQ-014 The following cases SHALL produce a single beat with out_err=1, out_last=1 and out_instr=base:
- a range or alignment violation, except the expandable case in REQ-015;
- imm_sel in 101..111;
- expand=1 with a non-I format.
REQ-015 Expansion applies when imm_sel=I, expand=1 and imm is outside the 12-bit range:
- Beat 1 SHALL be LUI: opcode 0110111, rd = base[11:7], upper = (imm + 32'h800)[31:12], out_last=0.
- Beat 2 SHALL be ADDI: opcode 0010011, funct3 000, rd = rs1 = base[11:7], imm12 = imm[11:0], out_last=1.
REQ-016 If an expandable imm has imm[11:0]=0, only the LUI beat SHALL be emitted, with out_last=1.
REQ-017 Addition in REQ-015 SHALL wrap modulo 2^32; no error is raised.
REQ-018 The FSM SHALL have three states:
- IDLE: no beat held.
- ONE: final beat held.
- HI: LUI beat held, ADDI pending.
REQ-019 FSM transitions SHALL be:
- IDLE -> ONE or HI on accept.
- HI -> ONE when out_ready=1; the ADDI beat appears the next cycle.
- ONE -> IDLE when out_ready=1 and there is no accept.
- ONE -> ONE or HI when out_ready=1 and there is an accept in the same cycle.
REQ-020 out_err SHALL be 0 on every beat of an expanded request.

Reset
REQ-021 When rst=1 at a clk edge, the block SHALL enter IDLE, and out_valid, out_err and out_last SHALL be 0 with out_instr = 32'h0.
REQ-022 A reset mid-expansion (in state HI) SHALL discard the pending ADDI beat.
REQ-023 While rst=1, in_ready SHALL be 0, and it SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-024 I format, base 32'h00000093, imm -1 -> one beat: 32'hFFF00093, out_err=0, out_last=1.
REQ-025 Three single-beat format checks, each with out_err=0:
- B format, base 32'h00000063, imm 8 -> 32'h00000463.
- J format, base 32'h0000006F, imm 2048 -> 32'h0010006F.
- U format, base 32'h00000037, imm 32'h00001000 -> 32'h00001037.
REQ-026 B format, imm 3 (misaligned) -> out_err=1, out_instr 32'h00000063.
- Same with imm_sel 111 -> out_err=1.
REQ-027 I format, expand=1, base 32'h00000093, imm 32'h12345FFF -> two beats:
- beat 1: 32'h123460B7, out_last=0;
- beat 2: 32'hFFF08093, out_last=1.
- in_ready SHALL be 0 between the two beats.
REQ-028 Backpressure: hold out_ready=0 for 3 cycles during the REQ-027 sequence.
- Beats SHALL stay stable while stalled and SHALL not be duplicated or dropped.
- A back-to-back request SHALL be accepted on the cycle the last beat drains.
REQ-029 Assert rst while in HI -> next cycle out_valid=0; the ADDI beat is never emitted.
